// File: rtl/amm_word_ram.sv
// amm_word_ram
//   Word-addressed 16-bit Avalon-MM slave backed by on-chip RAM. Each access
//   is stalled for WAIT_CYC cycles and then accepted. Read data returns
//   exactly RD_LAT cycles after the accept edge, in accept order.
//
// Parameters
//   ADDR_W   : RAM word address width (depth 2**ADDR_W words)
//   RD_LAT   : accept edge to amm_readdatavalid_o, 1..4 cycles
//   WAIT_CYC : waitrequest cycles per access, 0..3
//
// Ports
//   clk_i               : clock
//   rst_n_i             : asynchronous active-low reset
//   amm_address_i       : word address (bits above ADDR_W must be zero)
//   amm_read_i          : read request
//   amm_write_i         : write request (wins over a simultaneous read)
//   amm_writedata_i     : write data
//   amm_byteenable_i    : per-byte write enables
//   amm_readdata_o      : read data, held while readdatavalid is low
//   amm_readdatavalid_o : one-cycle pulse per returned read
//   amm_waitrequest_o   : slave stall
//   oor_cnt_o           : saturating count of accepted out-of-range accesses
//
// Build option
//   AMM_WORD_RAM_OOR_CNT_EN : when defined, builds the out-of-range counter.
//                             When undefined, oor_cnt_o is tied to zero.
module amm_word_ram #(
  parameter int ADDR_W   = 10,
  parameter int RD_LAT   = 2,
  parameter int WAIT_CYC = 1
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [30:0] amm_address_i,
  input  logic        amm_read_i,
  input  logic        amm_write_i,
  input  logic [15:0] amm_writedata_i,
  input  logic [1:0]  amm_byteenable_i,
  output logic [15:0] amm_readdata_o,
  output logic        amm_readdatavalid_o,
  output logic        amm_waitrequest_o,
  output logic [15:0] oor_cnt_o
);

  localparam logic [1:0]  ST_IDLE  = 2'd0;
  localparam logic [1:0]  ST_WAIT  = 2'd1;
  localparam logic [1:0]  ST_ACC   = 2'd2;
  localparam logic [15:0] OOR_DATA = 16'hDEAD;

  logic [15:0]       mem [2**ADDR_W];
  logic              req;
  logic              acc;
  logic              wr_acc;
  logic              rd_acc;
  logic              oor;
  logic [ADDR_W-1:0] idx;
  logic [15:0]       rd_word;

  assign req     = amm_read_i | amm_write_i;
  assign oor     = |amm_address_i[30:ADDR_W];
  assign idx     = amm_address_i[ADDR_W-1:0];
  assign rd_word = oor ? OOR_DATA : mem[idx];

  // Write takes priority; a read issued together with a write is dropped.
  assign wr_acc = acc & amm_write_i;
  assign rd_acc = acc & amm_read_i & ~amm_write_i;

  generate
    if (WAIT_CYC == 0) begin : g_nowait
      // Every request cycle is accepted; stall only while held in reset.
      assign acc               = req & rst_n_i;
      assign amm_waitrequest_o = ~rst_n_i;
    end else begin : g_wait
      logic [1:0] state_q;
      logic [1:0] state_d;
      logic [1:0] cnt_q;
      logic [1:0] cnt_d;

      // The IDLE cycle that sees the request is the first stall cycle, so
      // WAIT holds for WAIT_CYC-1 cycles: leave WAIT when cnt would reach 0.
      always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
          ST_IDLE: begin
            if (req) begin
              if (WAIT_CYC == 1) begin
                state_d = ST_ACC;
              end else begin
                state_d = ST_WAIT;
                cnt_d   = 2'(WAIT_CYC - 1);
              end
            end
          end
          ST_WAIT: begin
            if (!req) begin
              state_d = ST_IDLE;
            end else if (cnt_q <= 2'd1) begin
              state_d = ST_ACC;
              cnt_d   = 2'd0;
            end else begin
              cnt_d = cnt_q - 2'd1;
            end
          end
          ST_ACC:  state_d = ST_IDLE;
          default: state_d = ST_IDLE;
        endcase
      end

      always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
          state_q <= ST_IDLE;
          cnt_q   <= 2'd0;
        end else begin
          state_q <= state_d;
          cnt_q   <= cnt_d;
        end
      end

      assign acc               = (state_q == ST_ACC) & req;
      assign amm_waitrequest_o = (state_q != ST_ACC);
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (wr_acc && !oor) begin
      if (amm_byteenable_i[0]) mem[idx][7:0]  <= amm_writedata_i[7:0];
      if (amm_byteenable_i[1]) mem[idx][15:8] <= amm_writedata_i[15:8];
    end
  end

  // ---- read pipeline: stages p0..p(RD_LAT-2), then the output register ----
  logic        out_vld_d;
  logic [15:0] out_dat_d;

  generate
    if (RD_LAT == 1) begin : g_lat1
      assign out_vld_d = rd_acc;
      assign out_dat_d = rd_word;
    end else begin : g_latn
      logic [RD_LAT-2:0] vld_p_q;
      logic [RD_LAT-2:0] vld_p_d;
      logic [15:0]       dat_p_q [RD_LAT-1];
      logic [15:0]       dat_p_d [RD_LAT-1];

      always_comb begin
        vld_p_d    = '0;
        vld_p_d[0] = rd_acc;
        dat_p_d[0] = rd_word;
        for (int s = 1; s < RD_LAT - 1; s++) begin
          vld_p_d[s] = vld_p_q[s-1];
          dat_p_d[s] = dat_p_q[s-1];
        end
      end

      // Only valid bits are reset; that alone flushes in-flight reads.
      always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) vld_p_q <= '0;
        else          vld_p_q <= vld_p_d;
      end

      always_ff @(posedge clk_i) begin
        for (int s = 0; s < RD_LAT - 1; s++) dat_p_q[s] <= dat_p_d[s];
      end

      assign out_vld_d = vld_p_q[RD_LAT-2];
      assign out_dat_d = dat_p_q[RD_LAT-2];
    end
  endgenerate

  // ---- output stage: data register only loads on a returning read ----
  logic        rdv_q;
  logic        rdv_d;
  logic [15:0] rdata_q;
  logic [15:0] rdata_d;

  always_comb begin
    rdv_d   = out_vld_d;
    rdata_d = out_vld_d ? out_dat_d : rdata_q;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rdv_q   <= 1'b0;
      rdata_q <= 16'h0;
    end else begin
      rdv_q   <= rdv_d;
      rdata_q <= rdata_d;
    end
  end

  assign amm_readdatavalid_o = rdv_q;
  assign amm_readdata_o      = rdata_q;

`ifdef AMM_WORD_RAM_OOR_CNT_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0] oor_cnt_q;
  logic [15:0] oor_cnt_d;

  always_comb begin
    oor_cnt_d = (acc && oor) ? sat_inc16(oor_cnt_q) : oor_cnt_q;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) oor_cnt_q <= 16'h0;
    else          oor_cnt_q <= oor_cnt_d;
  end

  assign oor_cnt_o = oor_cnt_q;
`else
  assign oor_cnt_o = 16'h0;
`endif

endmodule

// File: tb/tb_amm_word_ram.sv
// Scoreboard bench for amm_word_ram: three instances with different wait /
// latency settings share clock and reset. A behavioural word-memory model
// predicts each read; expected responses are queued at accept time and a
// per-instance monitor pops and compares them when readdatavalid pulses.
module tb_amm_word_ram;

  localparam int N = 3;

  function automatic int wc(input int i);
    case (i)
      0:       return 1;
      1:       return 0;
      default: return 3;
    endcase
  endfunction

  function automatic int rl(input int i);
    case (i)
      0:       return 2;
      1:       return 3;
      default: return 1;
    endcase
  endfunction

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [30:0] addr  [N];
  logic        rd    [N];
  logic        wr    [N];
  logic [15:0] wdata [N];
  logic [1:0]  be    [N];
  logic [15:0] rdata [N];
  logic        rdv   [N];
  logic        wreq  [N];
  logic [15:0] oor_o [N];

  always #5 clk = ~clk;

  amm_word_ram #(.ADDR_W(10), .RD_LAT(2), .WAIT_CYC(1)) u_d0 (
    .clk_i(clk), .rst_n_i(rst_n), .amm_address_i(addr[0]), .amm_read_i(rd[0]),
    .amm_write_i(wr[0]), .amm_writedata_i(wdata[0]), .amm_byteenable_i(be[0]),
    .amm_readdata_o(rdata[0]), .amm_readdatavalid_o(rdv[0]),
    .amm_waitrequest_o(wreq[0]), .oor_cnt_o(oor_o[0]));

  amm_word_ram #(.ADDR_W(10), .RD_LAT(3), .WAIT_CYC(0)) u_d1 (
    .clk_i(clk), .rst_n_i(rst_n), .amm_address_i(addr[1]), .amm_read_i(rd[1]),
    .amm_write_i(wr[1]), .amm_writedata_i(wdata[1]), .amm_byteenable_i(be[1]),
    .amm_readdata_o(rdata[1]), .amm_readdatavalid_o(rdv[1]),
    .amm_waitrequest_o(wreq[1]), .oor_cnt_o(oor_o[1]));

  amm_word_ram #(.ADDR_W(10), .RD_LAT(1), .WAIT_CYC(3)) u_d2 (
    .clk_i(clk), .rst_n_i(rst_n), .amm_address_i(addr[2]), .amm_read_i(rd[2]),
    .amm_write_i(wr[2]), .amm_writedata_i(wdata[2]), .amm_byteenable_i(be[2]),
    .amm_readdata_o(rdata[2]), .amm_readdatavalid_o(rdv[2]),
    .amm_waitrequest_o(wreq[2]), .oor_cnt_o(oor_o[2]));

  typedef struct {
    logic [15:0] d;
    longint      t;
  } exp_t;

  exp_t        expq [N][$];
  logic [15:0] mdl  [N][16];
  longint      oorc [N];
  logic [15:0] last [N];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string nm, input int i, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s inst%0d: got 0x%0h, required 0x%0h", nm, i, got, exp);
    end
  endtask

  function automatic longint exp_oor(input int i);
    longint e;
    e = oorc[i];
`ifndef AMM_WORD_RAM_OOR_CNT_EN
    e = 0;
`endif
    return e;
  endfunction

  // Reference behaviour of one accepted access.
  task automatic model_accept(input int i, input bit r, input bit w, input logic [30:0] a,
                              input logic [15:0] d, input logic [1:0] b);
    bit   oor;
    exp_t e;
    oor = (a[30:10] != 21'h0);
    if (oor && oorc[i] < 65535) oorc[i]++;
    if (w) begin
      if (!oor) begin
        if (b[0]) mdl[i][a[3:0]][7:0]  = d[7:0];
        if (b[1]) mdl[i][a[3:0]][15:8] = d[15:8];
      end
    end else if (r) begin
      e.d = oor ? 16'hDEAD : mdl[i][a[3:0]];
      e.t = longint'($time) + rl(i) * 10 - 5;
      expq[i].push_back(e);
    end
  endtask

  // Called at a falling edge; holds the request until accepted.
  task automatic access(input int i, input bit r, input bit w, input logic [30:0] a,
                        input logic [15:0] d, input logic [1:0] b);
    int waits;
    bit done;
    addr[i] = a; rd[i] = r; wr[i] = w; wdata[i] = d; be[i] = b;
    waits = 0;
    done  = 0;
    for (int k = 0; k < 16 && !done; k++) begin
      #1;
      if (!wreq[i]) done = 1;
      else          waits++;
      @(posedge clk);
      if (done) model_accept(i, r, w, a, d, b);
      @(negedge clk);
    end
    rd[i] = 1'b0;
    wr[i] = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout inst%0d: waitrequest still high after 16 cycles, required release", i);
    end else begin
      chk("wait_cycles", i, waits, wc(i));
    end
  endtask

  for (genvar g = 0; g < N; g++) begin : g_mon
    always @(negedge clk) begin : mon
      exp_t e;
      if (!rst_n) begin
        last[g] = 16'h0;
      end else if (rdv[g]) begin
        if (expq[g].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rd_unexpected inst%0d: got readdatavalid with data 0x%0h, required none", g, rdata[g]);
        end else begin
          e = expq[g].pop_front();
          chk("rd_data", g, rdata[g], e.d);
          chk("rd_time", g, $time, e.t);
        end
        last[g] = rdata[g];
      end else begin
        chk("rd_hold", g, rdata[g], last[g]);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int          op;
    logic [30:0] a;
    for (int i = 0; i < N; i++) begin
      addr[i] = '0; rd[i] = 1'b0; wr[i] = 1'b0; wdata[i] = '0; be[i] = '0;
      oorc[i] = 0; last[i] = '0;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      chk("rst_waitreq", i, wreq[i], 1);
      chk("rst_rdv", i, rdv[i], 0);
      chk("rst_rdata", i, rdata[i], 0);
      chk("rst_oor", i, oor_o[i], 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < N; i++) chk("idle_waitreq", i, wreq[i], (wc(i) > 0) ? 1 : 0);
    @(negedge clk);

    for (int i = 0; i < N; i++) begin
      for (int k = 0; k < 16; k++) access(i, 0, 1, 31'(k), 16'(k), 2'b11);
      // write then read back, partial write, byteenable 00 no-op
      access(i, 0, 1, 31'd5, 16'h1234, 2'b11);
      access(i, 1, 0, 31'd5, 16'h0, 2'b00);
      access(i, 0, 1, 31'd7, 16'hFFFF, 2'b11);
      access(i, 0, 1, 31'd7, 16'hAB00, 2'b10);
      access(i, 1, 0, 31'd7, 16'h0, 2'b00);
      access(i, 0, 1, 31'd4, 16'hFFFF, 2'b00);
      access(i, 1, 0, 31'd4, 16'h0, 2'b00);
      // back-to-back reads (consecutive cycles when WAIT_CYC=0)
      access(i, 1, 0, 31'd0, 16'h0, 2'b00);
      access(i, 1, 0, 31'd1, 16'h0, 2'b00);
      access(i, 1, 0, 31'd2, 16'h0, 2'b00);
      // out-of-range read, write, then confirm no alias onto address 0
      access(i, 1, 0, 31'h400, 16'h0, 2'b00);
      access(i, 0, 1, 31'h400, 16'hBEEF, 2'b11);
      access(i, 1, 0, 31'd0, 16'h0, 2'b00);
      #1;
      chk("oor_cnt", i, oor_o[i], exp_oor(i));
      @(negedge clk);
      // simultaneous read+write: write wins, no read returned
      access(i, 1, 1, 31'd3, 16'h5555, 2'b11);
      access(i, 1, 0, 31'd3, 16'h0, 2'b00);
    end

    for (int i = 0; i < N; i++) begin
      repeat (100) begin
        op = $urandom_range(0, 9);
        if ($urandom_range(0, 7) == 0) a = 31'h400 | 31'($urandom_range(0, 2000000));
        else                           a = 31'($urandom_range(0, 15));
        access(i, (op < 4 || op >= 8), (op >= 4 && op <= 8), a,
               16'($urandom), 2'($urandom_range(0, 3)));
        if ($urandom_range(0, 3) == 0) @(negedge clk);
      end
      #1;
      chk("oor_cnt_rand", i, oor_o[i], exp_oor(i));
      @(negedge clk);
    end

    // reset while a read is in flight: it must never return
    access(0, 0, 1, 31'd9, 16'hC0DE, 2'b11);
    access(0, 1, 0, 31'd9, 16'h0, 2'b00);
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) begin
      expq[i].delete();
      oorc[i] = 0;
    end
    repeat (2) begin
      #1;
      for (int i = 0; i < N; i++) begin
        chk("midrst_waitreq", i, wreq[i], 1);
        chk("midrst_rdv", i, rdv[i], 0);
      end
      @(negedge clk);
    end
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      chk("postrst_oor", i, oor_o[i], 0);
      access(i, 1, 0, 31'd9, 16'h0, 2'b00);
      access(i, 1, 0, 31'd3, 16'h0, 2'b00);
    end

    repeat (8) @(negedge clk);
    for (int i = 0; i < N; i++) chk("queue_empty", i, expq[i].size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
